// File: rtl/mem_arb_pkg.sv
// Shared constants and the requester-select type for the unified SRAM port arbiter.
package mem_arb_pkg;

    localparam int SRAM_DW  = 32;
    localparam int STRB_W   = 4;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_INST = 2'd1,
        SEL_DATA = 2'd2
    } req_sel_e;

    // Data takes precedence because the two grants are exclusive by construction.
    function automatic req_sel_e pick_sel(input logic inst_gnt, input logic data_gnt);
        if (data_gnt) begin
            return SEL_DATA;
        end else if (inst_gnt) begin
            return SEL_INST;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_streak_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STREAK_W-1:0] LIMIT_V = STREAK_W'(LIMIT);

    logic [STREAK_W-1:0] count_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != LIMIT_V)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign at_limit = (count_reg == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter sharing one single-port SRAM between instruction fetch and data access,
// with data priority, a starvation cap for fetch, and one-cycle read response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_gnt,
    input  logic                inst_cancel,
    output logic                inst_rvalid,
    output logic [SRAM_DW-1:0]  inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [STRB_W-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [SRAM_DW-1:0]  data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [SRAM_DW-1:0]  data_rdata,

    output logic                sram_en,
    output logic [STRB_W-1:0]   sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]  sram_wdata,
    input  logic [SRAM_DW-1:0]  sram_rdata
);

    logic     at_limit;
    req_sel_e sel;
    logic     resp_i_reg;
    logic     resp_d_reg;

    // Fetch only overrides data once it has watched STARVE_LIMIT data grants go by.
    assign data_gnt = data_req && !(inst_req && at_limit);
    assign inst_gnt = inst_req && !data_gnt;
    assign sel      = pick_sel(inst_gnt, data_gnt);

    assign sram_en    = inst_gnt | data_gnt;
    assign sram_wen   = (data_gnt && data_wr) ? data_wstrb : '0;
    assign sram_wdata = data_wdata;

    always_comb begin
        sram_addr = data_addr;
        case (sel)
            SEL_INST: sram_addr = inst_addr;
            SEL_DATA: sram_addr = data_addr;
            default:  sram_addr = data_addr;
        endcase
    end

    arb_streak_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_streak (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (data_gnt && inst_req),
        .clr      (inst_gnt || !inst_req),
        .at_limit (at_limit)
    );

    // Writes finish at grant, so only data reads leave a response pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_i_reg <= 1'b0;
            resp_d_reg <= 1'b0;
        end else begin
            resp_i_reg <= inst_gnt;
            resp_d_reg <= data_gnt && !data_wr;
        end
    end

    assign inst_rvalid = resp_i_reg && !inst_cancel;
    assign data_rvalid = resp_d_reg;
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model and a reference copy of the SRAM contents.
module tb_mem_port_arbiter;

    localparam int LIMIT  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              inst_req = 1'b0;
    logic [ADDR_W-1:0] inst_addr = '0;
    logic              inst_gnt;
    logic              inst_cancel = 1'b0;
    logic              inst_rvalid;
    logic [31:0]       inst_rdata;
    logic              data_req = 1'b0;
    logic              data_wr = 1'b0;
    logic [3:0]        data_wstrb = '0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [31:0]       data_wdata = '0;
    logic              data_gnt;
    logic              data_rvalid;
    logic [31:0]       data_rdata;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_cancel (inst_cancel),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    // SRAM behavioural model driven by the DUT's SRAM port.
    logic [31:0] mem [16];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | 32'(i * 32'h0101);
            mem_ready <= 1'b1;
            sram_rdata <= '0;
        end else if (sram_en) begin
            if (|sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
            sram_rdata <= mem[sram_addr[5:2]];
        end
    end

    // Reference rules: data wins unless fetch has already waited through LIMIT data grants.
    function automatic logic exp_dg(input logic ireq, input logic dreq, input int streak);
        return dreq && !(ireq && streak == LIMIT);
    endfunction
    function automatic logic exp_ig(input logic ireq, input logic dreq, input int streak);
        return ireq && !exp_dg(ireq, dreq, streak);
    endfunction

    // Reference SRAM contents, updated from the model's own view of who was granted.
    logic [31:0] ref_mem [16];
    logic        ref_ready = 1'b0;
    int          m_streak;
    logic        m_resp_i, m_resp_d;
    logic [31:0] m_rdata;

    always @(posedge clk) begin
        if (!ref_ready) begin
            for (int i = 0; i < 16; i++) ref_mem[i] <= 32'hC0DE_0000 | 32'(i * 32'h0101);
            ref_ready <= 1'b1;
        end else if (resetn && exp_dg(inst_req, data_req, m_streak) && data_wr) begin
            for (int b = 0; b < 4; b++)
                if (data_wstrb[b]) ref_mem[data_addr[5:2]][8*b +: 8] <= data_wdata[8*b +: 8];
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_resp_i <= 1'b0;
            m_resp_d <= 1'b0;
            m_streak <= 0;
            m_rdata  <= '0;
        end else begin
            m_resp_i <= exp_ig(inst_req, data_req, m_streak);
            m_resp_d <= exp_dg(inst_req, data_req, m_streak) && !data_wr;
            m_rdata  <= exp_dg(inst_req, data_req, m_streak) ? ref_mem[data_addr[5:2]]
                                                             : ref_mem[inst_addr[5:2]];
            if (!inst_req || exp_ig(inst_req, data_req, m_streak)) m_streak <= 0;
            else if (exp_dg(inst_req, data_req, m_streak))         m_streak <= m_streak + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic compare_loop();
        logic eg_d, eg_i;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                eg_d = exp_dg(inst_req, data_req, m_streak);
                eg_i = exp_ig(inst_req, data_req, m_streak);
                chk("m_data_gnt", 32'(data_gnt), 32'(eg_d));
                chk("m_inst_gnt", 32'(inst_gnt), 32'(eg_i));
                chk("m_sram_en", 32'(sram_en), 32'(eg_d | eg_i));
                chk("m_sram_wen", 32'(sram_wen), (eg_d && data_wr) ? 32'(data_wstrb) : 32'd0);
                if (eg_d | eg_i) chk("m_sram_addr", sram_addr, eg_d ? data_addr : inst_addr);
                if (eg_d && data_wr) chk("m_sram_wdata", sram_wdata, data_wdata);
                chk("m_inst_rvalid", 32'(inst_rvalid), 32'(m_resp_i && !inst_cancel));
                chk("m_data_rvalid", 32'(data_rvalid), 32'(m_resp_d));
                if (m_resp_i && !inst_cancel) chk("m_inst_rdata", inst_rdata, m_rdata);
                if (m_resp_d) chk("m_data_rdata", data_rdata, m_rdata);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] dseq, iseq;
        logic [4:0] rseq;
        logic       ig, dg;
        fork
            compare_loop();
            begin
                @(posedge clk);
                chk_en = 1'b1;
                next_cycle();
                @(negedge clk);
                chk("rst_inst_rvalid", 32'(inst_rvalid), 32'd0);
                chk("rst_data_rvalid", 32'(data_rvalid), 32'd0);
                next_cycle();
                resetn = 1'b1;

                // Fetch alone for three cycles.
                inst_req  = 1'b1;
                inst_addr = 32'hbfc0_0000;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("io_inst_gnt", 32'(inst_gnt), 32'd1);
                    chk("io_sram_wen", 32'(sram_wen), 32'd0);
                    if (k > 0) chk("io_inst_rvalid", 32'(inst_rvalid), 32'd1);
                    next_cycle();
                end
                inst_req = 1'b0;
                @(negedge clk);
                chk("io_inst_rvalid_last", 32'(inst_rvalid), 32'd1);
                chk("io_rdata", inst_rdata, 32'hC0DE_0000);
                next_cycle();

                // Data read against fetch.
                inst_req  = 1'b1;
                data_req  = 1'b1;
                data_wr   = 1'b0;
                data_addr = 32'h8000_1000;
                @(negedge clk);
                chk("dr_data_gnt", 32'(data_gnt), 32'd1);
                chk("dr_inst_gnt", 32'(inst_gnt), 32'd0);
                next_cycle();
                data_req = 1'b0;
                @(negedge clk);
                chk("dr_data_rvalid", 32'(data_rvalid), 32'd1);
                chk("dr_inst_rvalid", 32'(inst_rvalid), 32'd0);
                next_cycle();
                inst_req = 1'b0;
                next_cycle();

                // Both held: LIMIT data grants, one fetch, then data again.
                inst_req = 1'b1;
                data_req = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    dseq[k] = data_gnt;
                    iseq[k] = inst_gnt;
                    next_cycle();
                end
                chk("sv_data_seq", 32'(dseq), 32'b101111);
                chk("sv_inst_seq", 32'(iseq), 32'b010000);
                inst_req = 1'b0;
                data_req = 1'b0;
                next_cycle();

                // Partial write.
                data_req   = 1'b1;
                data_wr    = 1'b1;
                data_wstrb = 4'b0011;
                data_wdata = 32'h1234_5678;
                data_addr  = 32'h8000_1004;
                @(negedge clk);
                chk("wr_sram_wen", 32'(sram_wen), 32'b0011);
                chk("wr_sram_wdata", sram_wdata, 32'h1234_5678);
                next_cycle();
                data_req = 1'b0;
                data_wr  = 1'b0;
                @(negedge clk);
                chk("wr_no_rvalid", 32'(data_rvalid), 32'd0);
                next_cycle();

                // Cancel kills only the due response, not a new fetch.
                inst_req = 1'b1;
                @(negedge clk);
                chk("cn_gnt_n", 32'(inst_gnt), 32'd1);
                next_cycle();
                inst_cancel = 1'b1;
                @(negedge clk);
                chk("cn_rvalid_n1", 32'(inst_rvalid), 32'd0);
                chk("cn_gnt_n1", 32'(inst_gnt), 32'd1);
                next_cycle();
                inst_cancel = 1'b0;
                inst_req    = 1'b0;
                @(negedge clk);
                chk("cn_rvalid_n2", 32'(inst_rvalid), 32'd1);
                next_cycle();

                // Build a streak of 3 ending in a data read, then reset asynchronously.
                inst_req = 1'b1;
                data_req = 1'b1;
                repeat (3) next_cycle();
                inst_req = 1'b0;
                data_req = 1'b0;
                #1;
                chk("ar_rvalid_before", 32'(data_rvalid), 32'd1);
                resetn = 1'b0;
                #1;
                chk("ar_rvalid_async", 32'(data_rvalid), 32'd0);
                next_cycle();
                resetn = 1'b1;
                inst_req = 1'b1;
                data_req = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    rseq[k] = data_gnt;
                    next_cycle();
                end
                chk("ar_streak_cleared", 32'(rseq), 32'b01111);
                inst_req = 1'b0;
                data_req = 1'b0;
                next_cycle();

                // Randomized requesters that hold until granted.
                for (int n = 0; n < 3000; n++) begin
                    @(negedge clk);
                    ig = inst_gnt;
                    dg = data_gnt;
                    next_cycle();
                    if (!inst_req || ig) begin
                        inst_req  = ($urandom % 4) != 0;
                        inst_addr = $urandom & 32'hFFFF_FFFC;
                    end
                    if (!data_req || dg) begin
                        data_req   = ($urandom % 3) != 0;
                        data_wr    = ($urandom % 2) != 0;
                        data_wstrb = 4'($urandom);
                        data_addr  = $urandom & 32'hFFFF_FFFC;
                        data_wdata = $urandom;
                    end
                    inst_cancel = ($urandom % 4) == 0;
                end
                @(negedge clk);
                next_cycle();
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
